mem_stage_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 51 +++++
 rtl/load_ext.sv | 35 +++
 rtl/mem_stage_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared memory-stage op encodings, exception codes and predicates.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } mem_op_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic is_store(input logic [2:0] op);
    return (op >= OP_SW);
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return !is_store(op);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] b);
    case (op)
      OP_LW, OP_SW:         return (b != 2'b00);
      OP_LH, OP_LHU, OP_SH: return b[0];
      default:              return 1'b0;
    endcase
  endfunction

  // Offset with the alignment bits masked off by access size.
  function automatic logic [1:0] align_offset(input logic [2:0] op, input logic [1:0] b);
    case (op)
      OP_LW, OP_SW:         return 2'b00;
      OP_LH, OP_LHU, OP_SH: return {b[1], 1'b0};
      default:              return b;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_ext.sv
// ============================================================================
// Module   : load_ext
// Brief    : Combinational load lane select and sign/zero extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_ext
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[{offset, 3'b000} +: 8];
    w_half = offset[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LW:   data = word;
      OP_LH:   data = {{16{w_half[15]}}, w_half};
      OP_LHU:  data = {16'h0000, w_half};
      OP_LB:   data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  data = {24'h000000, w_byte};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : MEM-stage controller: EX/MEM + MEM/WB registers, data-memory
//            drive, load extension. Optional MEM_ALIGN_CHECK_EN enables
//            misalignment detection, suppression and mem_exc reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int DM_AW = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_wdata,
  input  logic [4:0]       ex_rd,
  input  logic             mem_stall,
  input  logic             mem_flush,
  output logic [DM_AW-1:0] dm_a,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_wd,
  output logic             dm_we,
  input  logic [31:0]      dm_rd,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_wdata,
  output logic             mem_exc,
  output logic [4:0]       mem_exc_code
);

  logic             r_valid;
  logic [2:0]       r_op;
  logic [DM_AW+1:0] r_addr;
  logic [31:0]      r_wdata;
  logic [4:0]       r_rd;
  logic             r_wr_done;

  logic [1:0]       w_b;
  logic             w_mis;
  logic [31:0]      w_ext;
  logic             w_unused;

  assign w_unused = &{1'b0, ex_addr[31:DM_AW+2]};

`ifdef MEM_ALIGN_CHECK_EN
  logic w_ex_mis;

  assign w_mis    = is_misaligned(r_op, r_addr[1:0]);
  assign w_b      = r_addr[1:0];
  assign w_ex_mis = is_misaligned(ex_op, ex_addr[1:0]);

  // Raised at capture so the pulse lands on the first MEM cycle only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_exc      <= 1'b0;
      mem_exc_code <= 5'd0;
    end else if (!mem_flush && !mem_stall && ex_valid && w_ex_mis) begin
      mem_exc      <= 1'b1;
      mem_exc_code <= is_store(ex_op) ? EXC_ADES : EXC_ADEL;
    end else begin
      mem_exc      <= 1'b0;
      mem_exc_code <= 5'd0;
    end
  end
`else
  assign w_mis        = 1'b0;
  assign w_b          = align_offset(r_op, r_addr[1:0]);
  assign mem_exc      = 1'b0;
  assign mem_exc_code = 5'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_op      <= 3'b000;
      r_addr    <= '0;
      r_wdata   <= 32'h0000_0000;
      r_rd      <= 5'd0;
      r_wr_done <= 1'b0;
    end else if (mem_flush) begin
      r_valid   <= 1'b0;
      r_wr_done <= 1'b0;
    end else if (!mem_stall) begin
      r_valid   <= ex_valid;
      r_op      <= ex_op;
      r_addr    <= ex_addr[DM_AW+1:0];
      r_wdata   <= ex_wdata;
      r_rd      <= ex_rd;
      r_wr_done <= 1'b0;
    end else if (dm_we) begin
      // Held store already committed; block re-writes for the rest of the stall.
      r_wr_done <= 1'b1;
    end
  end

  assign dm_a  = r_addr[DM_AW+1:2];
  assign dm_we = r_valid && is_store(r_op) && !w_mis && !r_wr_done;

  always_comb begin
    dm_be = 4'b0000;
    if (r_valid && !w_mis) begin
      case (r_op)
        OP_SW:   dm_be = 4'b1111;
        OP_SH:   dm_be = w_b[1] ? 4'b1100 : 4'b0011;
        OP_SB:   dm_be = 4'b0001 << w_b;
        default: dm_be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (r_op)
      OP_SH:   dm_wd = {2{r_wdata[15:0]}};
      OP_SB:   dm_wd = {4{r_wdata[7:0]}};
      default: dm_wd = r_wdata;
    endcase
  end

  load_ext u_load_ext (
    .op     (r_op),
    .offset (w_b),
    .word   (dm_rd),
    .data   (w_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_wdata <= 32'h0000_0000;
    end else if (mem_stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= r_valid && is_load(r_op) && !w_mis;
      wb_rd    <= r_rd;
      wb_wdata <= w_ext;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Directed self-checking bench for mem_stage_ctrl with a memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_stage_ctrl;
  import mem_pkg::*;

  localparam int DM_AW = 11;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ex_valid;
  logic [2:0]       ex_op;
  logic [31:0]      ex_addr;
  logic [31:0]      ex_wdata;
  logic [4:0]       ex_rd;
  logic             mem_stall;
  logic             mem_flush;
  logic [DM_AW-1:0] dm_a;
  logic [3:0]       dm_be;
  logic [31:0]      dm_wd;
  logic             dm_we;
  logic [31:0]      dm_rd;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_wdata;
  logic             mem_exc;
  logic [4:0]       mem_exc_code;

  int checks   = 0;
  int failures = 0;
  int we_pulses = 0;
  int wb_pulses = 0;
  int we_base, wb_base;

  logic [31:0] dmem [0:(1<<DM_AW)-1];
  logic        mem_clear;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DM_AW(DM_AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .mem_stall    (mem_stall),
    .mem_flush    (mem_flush),
    .dm_a         (dm_a),
    .dm_be        (dm_be),
    .dm_wd        (dm_wd),
    .dm_we        (dm_we),
    .dm_rd        (dm_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_wdata     (wb_wdata),
    .mem_exc      (mem_exc),
    .mem_exc_code (mem_exc_code)
  );

  // Byte-enabled data memory consuming the aligned lanes.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < (1<<DM_AW); i++) dmem[i] <= 32'h0;
    end else if (dm_we) begin
      for (int l = 0; l < 4; l++)
        if (dm_be[l]) dmem[dm_a][8*l +: 8] <= dm_wd[8*l +: 8];
    end
  end
  assign dm_rd = dmem[dm_a];

  always @(negedge clk) begin
    if (dm_we === 1'b1)    we_pulses++;
    if (wb_valid === 1'b1) wb_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_addr  = addr;
    ex_wdata = wdata;
    ex_rd    = rd;
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; mem_clear = 1'b1;
    ex_valid = 1'b0; ex_op = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    mem_stall = 1'b0; mem_flush = 1'b0;
    repeat (2) tick();

    check_eq("rst_dm_we",    {31'b0, dm_we}, 32'h0);
    check_eq("rst_dm_be",    {28'b0, dm_be}, 32'h0);
    check_eq("rst_dm_a",     {21'b0, dm_a}, 32'h0);
    check_eq("rst_dm_wd",    dm_wd, 32'h0);
    check_eq("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    check_eq("rst_wb_rd",    {27'b0, wb_rd}, 32'h0);
    check_eq("rst_wb_wdata", wb_wdata, 32'h0);
    check_eq("rst_mem_exc",  {31'b0, mem_exc}, 32'h0);
    check_eq("rst_exc_code", {27'b0, mem_exc_code}, 32'h0);

    mem_clear = 1'b0;
    reset_n   = 1'b1;
    tick();

    // SB lane 3, then read back as word, signed byte, unsigned byte
    issue(OP_SB, 32'h0000_1003, 32'h0000_00A5, 5'd0);
    check_eq("sb_dm_a",  {21'b0, dm_a}, 32'h400);
    check_eq("sb_dm_be", {28'b0, dm_be}, 32'h8);
    check_eq("sb_dm_wd", dm_wd, 32'hA5A5_A5A5);
    check_eq("sb_dm_we", {31'b0, dm_we}, 32'h1);
    tick();
    check_eq("sb_we_drop", {31'b0, dm_we}, 32'h0);
    check_eq("sb_mem",     dmem[11'h400], 32'hA500_0000);
    issue(OP_LW, 32'h0000_1000, 32'h0, 5'd3);
    issue(OP_LB, 32'h0000_1003, 32'h0, 5'd4);
    check_eq("lw_wb_valid", {31'b0, wb_valid}, 32'h1);
    check_eq("lw_wb_rd",    {27'b0, wb_rd}, 32'd3);
    check_eq("lw_wb_wdata", wb_wdata, 32'hA500_0000);
    issue(OP_LBU, 32'h0000_1003, 32'h0, 5'd5);
    check_eq("lb_wb_rd",    {27'b0, wb_rd}, 32'd4);
    check_eq("lb_wb_wdata", wb_wdata, 32'hFFFF_FFA5);
    tick();
    check_eq("lbu_wb_rd",    {27'b0, wb_rd}, 32'd5);
    check_eq("lbu_wb_wdata", wb_wdata, 32'h0000_00A5);

    // SH upper half, immediately followed by LH then LHU of same address
    issue(OP_SH, 32'h0000_0012, 32'h0000_BEEF, 5'd0);
    check_eq("sh_dm_a",  {21'b0, dm_a}, 32'h4);
    check_eq("sh_dm_be", {28'b0, dm_be}, 32'hC);
    check_eq("sh_dm_wd", dm_wd, 32'hBEEF_BEEF);
    check_eq("sh_dm_we", {31'b0, dm_we}, 32'h1);
    issue(OP_LH, 32'h0000_0012, 32'h0, 5'd6);
    check_eq("lh_no_we", {31'b0, dm_we}, 32'h0);
    check_eq("lh_be",    {28'b0, dm_be}, 32'h0);
    issue(OP_LHU, 32'h0000_0012, 32'h0, 5'd7);
    check_eq("lh_wb_valid", {31'b0, wb_valid}, 32'h1);
    check_eq("lh_wb_rd",    {27'b0, wb_rd}, 32'd6);
    check_eq("lh_wb_wdata", wb_wdata, 32'hFFFF_BEEF);
    tick();
    check_eq("lhu_wb_valid", {31'b0, wb_valid}, 32'h1);
    check_eq("lhu_wb_rd",    {27'b0, wb_rd}, 32'd7);
    check_eq("lhu_wb_wdata", wb_wdata, 32'h0000_BEEF);
    tick();
    check_eq("bubble_wb_valid", {31'b0, wb_valid}, 32'h0);

    // SW held three cycles by stall: exactly one write
    we_base = we_pulses;
    wb_base = wb_pulses;
    ex_valid = 1'b1; ex_op = OP_SW; ex_addr = 32'h20; ex_wdata = 32'h1234_5678; ex_rd = 5'd9;
    tick();
    ex_valid  = 1'b0;
    mem_stall = 1'b1;
    tick();
    check_eq("stall_we_held_off", {31'b0, dm_we}, 32'h0);
    repeat (2) tick();
    mem_stall = 1'b0;
    tick();
    check_eq("stall_we_pulses", we_pulses - we_base, 32'd1);
    check_eq("stall_wb_pulses", wb_pulses - wb_base, 32'd0);
    check_eq("stall_mem",       dmem[11'h8], 32'h1234_5678);

    // Misaligned LW
    issue(OP_LW, 32'h0000_0022, 32'h0, 5'd10);
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("mis_lw_exc",  {31'b0, mem_exc}, 32'h1);
    check_eq("mis_lw_code", {27'b0, mem_exc_code}, 32'd4);
    tick();
    check_eq("mis_lw_exc_once", {31'b0, mem_exc}, 32'h0);
    check_eq("mis_lw_no_wb",    {31'b0, wb_valid}, 32'h0);
    ex_valid = 1'b1; ex_op = OP_SW; ex_addr = 32'h21; ex_wdata = 32'hDEAD_BEEF; ex_rd = 5'd0;
    tick();
    ex_valid  = 1'b0;
    mem_stall = 1'b1;
    check_eq("mis_sw_exc",   {31'b0, mem_exc}, 32'h1);
    check_eq("mis_sw_code",  {27'b0, mem_exc_code}, 32'd5);
    check_eq("mis_sw_no_we", {31'b0, dm_we}, 32'h0);
    tick();
    check_eq("mis_sw_no_repeat", {31'b0, mem_exc}, 32'h0);
    mem_stall = 1'b0;
    tick();
    check_eq("mis_sw_mem_kept", dmem[11'h8], 32'h1234_5678);
`else
    check_eq("unaligned_lw_exc", {31'b0, mem_exc}, 32'h0);
    tick();
    check_eq("unaligned_lw_valid", {31'b0, wb_valid}, 32'h1);
    check_eq("unaligned_lw_wdata", wb_wdata, 32'h1234_5678);
    check_eq("unaligned_lw_exc2",  {31'b0, mem_exc}, 32'h0);
`endif

    // Stall and flush together with SB in MEM
    issue(OP_SB, 32'h0000_0030, 32'h0000_0011, 5'd0);
    mem_stall = 1'b1;
    mem_flush = 1'b1;
    tick();
    mem_stall = 1'b0;
    mem_flush = 1'b0;
    check_eq("flush_we",  {31'b0, dm_we}, 32'h0);
    check_eq("flush_be",  {28'b0, dm_be}, 32'h0);
    check_eq("flush_exc", {31'b0, mem_exc}, 32'h0);
    tick();
    check_eq("flush_wb_valid", {31'b0, wb_valid}, 32'h0);

    // Reset pulse while SW sits in MEM
    issue(OP_SW, 32'h0000_0040, 32'hCAFE_F00D, 5'd0);
    check_eq("pre_rst_we", {31'b0, dm_we}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_we",       {31'b0, dm_we}, 32'h0);
    check_eq("mid_rst_be",       {28'b0, dm_be}, 32'h0);
    check_eq("mid_rst_dm_a",     {21'b0, dm_a}, 32'h0);
    check_eq("mid_rst_dm_wd",    dm_wd, 32'h0);
    check_eq("mid_rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    check_eq("mid_rst_wb_rd",    {27'b0, wb_rd}, 32'h0);
    check_eq("mid_rst_wb_wdata", wb_wdata, 32'h0);
    check_eq("mid_rst_exc",      {31'b0, mem_exc}, 32'h0);
    tick();
    reset_n = 1'b1;
    check_eq("mid_rst_no_write", dmem[11'h10], 32'h0);
    tick();
    check_eq("post_rst_we", {31'b0, dm_we}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
